acr_packet_generator: RTL

Parametrised HDMI Audio Clock Regeneration (ACR) packet source. It measures CTS entirely in the `clk_pixel` domain by counting pixel clocks across N/128 audio sample strobes, and averages the measurement over 2^AVG_LOG2 windows. The audio rate is selected at run time from the seven standard HDMI rates. It presents a ready-formatted ACR packet (HB + four identical subpackets) to the packet scheduler through a valid/ack handshake, and reports lock status to the HDMI top level.

---
 rtl/acr_packet_generator.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/acr_packet_generator.sv
// -----------------------------------------------------------------------------
// acr_packet_generator
//
// HDMI Audio Clock Regeneration packet source. CTS is measured in the pixel
// clock domain by counting pixel clocks across windows of N/128 audio sample
// strobes. The count is averaged over 2^AVG_LOG2 windows and published as a
// ready-formatted ACR packet (header + four identical subpackets) behind a
// valid/ack handshake.
//
// Parameters:
//   VIDEO_RATE  pixel clock rate in Hz (documentation only)
//   CTS_WIDTH   width of the cycle counter and of CTS, 1..20
//   AVG_LOG2    log2 of windows averaged per published CTS, 0..4
//
// Ports:
//   clk_pixel       in   pixel clock, all logic on its rising edge
//   reset           in   asynchronous active-high reset
//   audio_rate_sel  in 3 0=32k 1=44.1k 2=48k 3=88.2k 4=96k 5=176.4k 6=192k 7=48k
//   sample_strobe   in   one-cycle pulse per audio sample
//   packet_ack      in   scheduler consumed the current packet
//   packet_valid    out  packet contents valid and unconsumed
//   header          out 24 ACR header bytes {HB2, HB1, HB0}
//   sub             out 4x56 four identical ACR subpackets, sub[i] = sub[56*i +: 56]
//   cts_value       out 20 current published CTS (zero-extended)
//   cts_locked      out  an averaged CTS has been published since last restart
// -----------------------------------------------------------------------------
module acr_packet_generator #(
  parameter real VIDEO_RATE = 25.2E6,
  parameter int  CTS_WIDTH  = 20,
  parameter int  AVG_LOG2   = 2
) (
  input  logic         clk_pixel,
  input  logic         reset,
  input  logic [2:0]   audio_rate_sel,
  input  logic         sample_strobe,
  input  logic         packet_ack,
  output logic         packet_valid,
  output logic [23:0]  header,
  output logic [223:0] sub,
  output logic [19:0]  cts_value,
  output logic         cts_locked
);

  localparam int                   ACC_W    = CTS_WIDTH + AVG_LOG2;
  localparam logic [CTS_WIDTH-1:0] CYC_MAX  = '1;
  localparam logic [4:0]           WIN_LAST = 5'((1 << AVG_LOG2) - 1);

  if (CTS_WIDTH < 1 || CTS_WIDTH > 20 || AVG_LOG2 < 0 || AVG_LOG2 > 4 ||
      VIDEO_RATE <= 0.0) begin : g_param_check
    $error("acr_packet_generator: parameter out of range");
  end

  typedef enum logic {
    ST_WAIT_START,
    ST_MEASURE
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_rate, w_rate_nxt;
  logic [CTS_WIDTH-1:0]  r_cycle_cnt, w_cycle_cnt_nxt;
  logic [7:0]            r_sample_cnt, w_sample_cnt_nxt;
  logic [ACC_W-1:0]      r_acc, w_acc_nxt;
  logic [4:0]            r_win_cnt, w_win_cnt_nxt;
  logic [CTS_WIDTH-1:0]  r_cts, w_cts_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_locked, w_locked_nxt;

  logic [19:0]           w_n;
  logic [7:0]            w_win_len;
  logic [ACC_W-1:0]      w_sum;
  logic [19:0]           w_cts20;
  logic [55:0]           w_sub;

  // N follows the registered rate; code 7 falls back to 48k.
  always_comb begin
    w_n = 20'd6144;
    case (r_rate)
      3'd0:    w_n = 20'd4096;
      3'd1:    w_n = 20'd6272;
      3'd2:    w_n = 20'd6144;
      3'd3:    w_n = 20'd12544;
      3'd4:    w_n = 20'd12288;
      3'd5:    w_n = 20'd25088;
      3'd6:    w_n = 20'd24576;
      default: w_n = 20'd6144;
    endcase
  end

  // Window length in strobes is N/128; every N in the table is below 2^15.
  assign w_win_len = w_n[14:7];

  // Accumulator plus the length of the window closing on this strobe; the
  // cycle counter holds length-1 because it restarts at zero after a boundary.
  assign w_sum = r_acc + ACC_W'(r_cycle_cnt) + ACC_W'(1);

  always_comb begin
    // NOTE: every next-state value is defaulted to its hold value first, so no
    // path through the branches below can leave a signal unassigned (latch).
    w_state_nxt      = r_state;
    w_rate_nxt       = r_rate;
    w_cycle_cnt_nxt  = r_cycle_cnt;
    w_sample_cnt_nxt = r_sample_cnt;
    w_acc_nxt        = r_acc;
    w_win_cnt_nxt    = r_win_cnt;
    w_cts_nxt        = r_cts;
    w_valid_nxt      = r_valid;
    w_locked_nxt     = r_locked;

    // Ack clears valid; a publish later in this block overrides it.
    if (packet_ack) w_valid_nxt = 1'b0;

    if (audio_rate_sel != r_rate || (r_state == ST_MEASURE && r_cycle_cnt == CYC_MAX)) begin
      // Restart on rate change or on timeout (audio stopped); CTS is kept.
      w_rate_nxt       = audio_rate_sel;
      w_state_nxt      = ST_WAIT_START;
      w_cycle_cnt_nxt  = '0;
      w_sample_cnt_nxt = '0;
      w_acc_nxt        = '0;
      w_win_cnt_nxt    = '0;
      w_valid_nxt      = 1'b0;
      w_locked_nxt     = 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_START: begin
          if (sample_strobe) begin
            w_cycle_cnt_nxt  = '0;
            w_sample_cnt_nxt = '0;
            w_state_nxt      = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          w_cycle_cnt_nxt = r_cycle_cnt + 1'b1;
          if (sample_strobe) begin
            if (r_sample_cnt == w_win_len - 8'd1) begin
              // Boundary strobe closes this window and opens the next.
              w_cycle_cnt_nxt  = '0;
              w_sample_cnt_nxt = '0;
              if (r_win_cnt == WIN_LAST) begin
                w_cts_nxt     = w_sum[AVG_LOG2 +: CTS_WIDTH];
                w_valid_nxt   = 1'b1;
                w_locked_nxt  = 1'b1;
                w_acc_nxt     = '0;
                w_win_cnt_nxt = '0;
              end else begin
                w_acc_nxt     = w_sum;
                w_win_cnt_nxt = r_win_cnt + 5'd1;
              end
            end else begin
              w_sample_cnt_nxt = r_sample_cnt + 8'd1;
            end
          end
        end
        default: w_state_nxt = ST_WAIT_START;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state      <= ST_WAIT_START;
      r_rate       <= 3'd2;
      r_cycle_cnt  <= '0;
      r_sample_cnt <= '0;
      r_acc        <= '0;
      r_win_cnt    <= '0;
      r_cts        <= '0;
      r_valid      <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rate       <= w_rate_nxt;
      r_cycle_cnt  <= w_cycle_cnt_nxt;
      r_sample_cnt <= w_sample_cnt_nxt;
      r_acc        <= w_acc_nxt;
      r_win_cnt    <= w_win_cnt_nxt;
      r_cts        <= w_cts_nxt;
      r_valid      <= w_valid_nxt;
      r_locked     <= w_locked_nxt;
    end
  end

  assign w_cts20 = 20'(r_cts);

  assign w_sub = {w_n[7:0], w_n[15:8], {4'd0, w_n[19:16]},
                  w_cts20[7:0], w_cts20[15:8], {4'd0, w_cts20[19:16]}, 8'd0};

  assign header       = {8'd0, 8'd0, 8'd1};
  assign sub          = {4{w_sub}};
  assign cts_value    = w_cts20;
  assign packet_valid = r_valid;
  assign cts_locked   = r_locked;

endmodule
